// File: rtl/dense_sched_if.sv
// Purpose: bundles the dense sequencer's controller and datapath signals into one port.
// Latency: none; wires only.
// Backpressure: fm_ready is the only stall input; nothing flows back from the datapath otherwise.
// Ports: start/busy/done/class_id/class_score face the layer controller; fm_ready, row/col/
//        channelCount, weightAddr1/2, wmem_load, mac_*, acc_clear, res_sel/res_val face the datapath.
// Optional: DENSE_PERF_EN adds perf_stall (RUN cycles spent waiting on fm_ready).
interface dense_sched_if #(
    parameter int WEIGHT_ADDR_LEN = 10
);
    logic                       start;
    logic                       fm_ready;
    logic signed [7:0]          res_val;
    logic [4:0]                 row;
    logic [4:0]                 col;
    logic [4:0]                 channelCount;
    logic [WEIGHT_ADDR_LEN:0]   weightAddr1;
    logic [WEIGHT_ADDR_LEN:0]   weightAddr2;
    logic                       wmem_load;
    logic                       mac_valid;
    logic                       mac_lane2;
    logic [4:0]                 mac_ch;
    logic                       acc_clear;
    logic [3:0]                 res_sel;
    logic                       busy;
    logic                       done;
    logic [3:0]                 class_id;
    logic signed [7:0]          class_score;
`ifdef DENSE_PERF_EN
    logic [15:0]                perf_stall;

    modport master (
        input  start, fm_ready, res_val,
        output row, col, channelCount, weightAddr1, weightAddr2, wmem_load,
               mac_valid, mac_lane2, mac_ch, acc_clear, res_sel,
               busy, done, class_id, class_score, perf_stall
    );
    modport slave (
        output start, fm_ready, res_val,
        input  row, col, channelCount, weightAddr1, weightAddr2, wmem_load,
               mac_valid, mac_lane2, mac_ch, acc_clear, res_sel,
               busy, done, class_id, class_score, perf_stall
    );
`else
    modport master (
        input  start, fm_ready, res_val,
        output row, col, channelCount, weightAddr1, weightAddr2, wmem_load,
               mac_valid, mac_lane2, mac_ch, acc_clear, res_sel,
               busy, done, class_id, class_score
    );
    modport slave (
        output start, fm_ready, res_val,
        input  row, col, channelCount, weightAddr1, weightAddr2, wmem_load,
               mac_valid, mac_lane2, mac_ch, acc_clear, res_sel,
               busy, done, class_id, class_score
    );
`endif
endinterface

// File: rtl/dense_sched.sv
// Purpose: dense-stage sequencer; walks channel/row/column-pair, issues weight reads and MAC strobes, then arg-max scan.
// Latency: mac_* trail the accepted beat by WMEM_LAT; done follows the last beat by WMEM_LAT+MAC_LAT+NC+3 cycles.
// Backpressure: fm_ready=0 in RUN freezes counters/addresses and inserts mac_valid bubbles; no timeout.
// Ports: clk, rst (async active-low), bus (dense_sched_if.master) carrying all control/data signals.
// Optional: define DENSE_PERF_EN to add the saturating perf_stall counter.
module dense_sched #(
    parameter int NC              = 9,
    parameter int OC              = 15,
    parameter int ROWS            = 14,
    parameter int COLS            = 14,
    parameter int WPC             = 49,
    parameter int WROW            = 7,
    parameter int WEIGHT_ADDR_LEN = 10,
    parameter int WMEM_LAT        = 1,
    parameter int MAC_LAT         = 2
) (
    input  logic          clk,
    input  logic          rst,
    dense_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, SCAN, FIN} state_t;

    localparam int         AW         = WEIGHT_ADDR_LEN + 1;
    localparam logic [4:0] CH_LAST    = 5'(OC);
    localparam logic [4:0] ROW_LAST   = 5'(ROWS - 1);
    localparam logic [4:0] COL_LAST   = 5'(((COLS - 1) / 2) * 2);
    localparam logic [5:0] COLS_W     = 6'(COLS);
    localparam logic [7:0] DRAIN_LAST = 8'(WMEM_LAT + MAC_LAT - 1);
    localparam logic [4:0] SEL_LAST   = 5'(NC);
    localparam logic [4:0] SCAN_LAST  = 5'(NC + 1);

    state_t                   state_q, state_d;
    logic [4:0]               row_q, row_d, col_q, col_d, ch_q, ch_d;
    logic [WMEM_LAT-1:0]      vld_pipe_q, vld_pipe_d, lane_pipe_q, lane_pipe_d;
    logic [WMEM_LAT-1:0][4:0] ch_pipe_q, ch_pipe_d;
    logic                     acc_clear_q, acc_clear_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]               res_sel_q, res_sel_d, class_id_q, class_id_d, best_idx_q, best_idx_d;
    logic signed [7:0]        class_score_q, class_score_d, best_q, best_d;
    logic [4:0]               scan_cnt_q, scan_cnt_d;
    logic [7:0]               drain_cnt_q, drain_cnt_d;
    logic                     in_run, accept, last_beat, lane2;
    logic [AW-1:0]            addr;
`ifdef DENSE_PERF_EN
    logic [15:0]              perf_q, perf_d;
`endif

    assign in_run    = (state_q == RUN);
    assign accept    = in_run & bus.fm_ready;
    assign last_beat = (ch_q == CH_LAST) && (row_q == ROW_LAST) && (col_q == COL_LAST);
    // Odd COLS leaves the final pair with only lane 0 populated.
    assign lane2     = ({1'b0, col_q} + 6'd1) < COLS_W;
    // Two feature rows/cols share one weight row/col, hence the halving.
    assign addr      = AW'(ch_q) * AW'(WPC) + AW'(row_q >> 1) * AW'(WROW) + AW'(col_q >> 1);

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        ch_d          = ch_q;
        acc_clear_d   = acc_clear_q;
        busy_d        = busy_q;
        done_d        = done_q;
        res_sel_d     = res_sel_q;
        class_id_d    = class_id_q;
        class_score_d = class_score_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        scan_cnt_d    = scan_cnt_q;
        drain_cnt_d   = drain_cnt_q;
`ifdef DENSE_PERF_EN
        perf_d        = perf_q;
`endif
        // Delay line matching the weight-memory read latency.
        vld_pipe_d[0]  = accept;
        lane_pipe_d[0] = lane2;
        ch_pipe_d[0]   = ch_q;
        for (int i = 1; i < WMEM_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            lane_pipe_d[i] = lane_pipe_q[i-1];
            ch_pipe_d[i]   = ch_pipe_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = CLR;
                    busy_d      = 1'b1;
                    acc_clear_d = 1'b1;
                end
            end
            CLR: begin
                acc_clear_d = 1'b0;
                row_d       = '0;
                col_d       = '0;
                ch_d        = '0;
                state_d     = RUN;
`ifdef DENSE_PERF_EN
                perf_d      = '0;
`endif
            end
            RUN: begin
                if (bus.fm_ready) begin
                    if (last_beat) begin
                        // Counters stay on the final coordinate rather than overflowing the channel.
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            ch_d  = ch_q + 5'd1;
                        end else begin
                            row_d = row_q + 5'd1;
                        end
                    end else begin
                        col_d = col_q + 5'd2;
                    end
                end
`ifdef DENSE_PERF_EN
                else if (perf_q != 16'hFFFF) begin
                    perf_d = perf_q + 16'd1;
                end
`endif
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d    = SCAN;
                    res_sel_d  = '0;
                    scan_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            SCAN: begin
                // scan_cnt k drives res_sel=k and compares the result of class k-1.
                scan_cnt_d = scan_cnt_q + 5'd1;
                if (scan_cnt_q < SEL_LAST) begin
                    res_sel_d = res_sel_q + 4'd1;
                end
                if (scan_cnt_q != 5'd0) begin
                    // Strictly-greater keeps the lowest index on ties.
                    if ((scan_cnt_q == 5'd1) || (bus.res_val > best_q)) begin
                        best_d     = bus.res_val;
                        best_idx_d = 4'(scan_cnt_q - 5'd1);
                    end
                end
                if (scan_cnt_q == SCAN_LAST) begin
                    class_id_d    = best_idx_d;
                    class_score_d = best_d;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = FIN;
                end
            end
            FIN: begin
                done_d    = 1'b0;
                res_sel_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            ch_q          <= '0;
            vld_pipe_q    <= '0;
            lane_pipe_q   <= '0;
            ch_pipe_q     <= '0;
            acc_clear_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            res_sel_q     <= '0;
            class_id_q    <= '0;
            class_score_q <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            scan_cnt_q    <= '0;
            drain_cnt_q   <= '0;
`ifdef DENSE_PERF_EN
            perf_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            ch_q          <= ch_d;
            vld_pipe_q    <= vld_pipe_d;
            lane_pipe_q   <= lane_pipe_d;
            ch_pipe_q     <= ch_pipe_d;
            acc_clear_q   <= acc_clear_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            res_sel_q     <= res_sel_d;
            class_id_q    <= class_id_d;
            class_score_q <= class_score_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            scan_cnt_q    <= scan_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
`ifdef DENSE_PERF_EN
            perf_q        <= perf_d;
`endif
        end
    end

    assign bus.row          = row_q;
    assign bus.col          = col_q;
    assign bus.channelCount = ch_q;
    // Addresses are only meaningful in RUN; forcing zero elsewhere keeps the idle/reset bus quiet.
    assign bus.weightAddr1  = in_run ? addr : '0;
    assign bus.weightAddr2  = in_run ? addr + AW'(1) : '0;
    assign bus.wmem_load    = accept;
    assign bus.mac_valid    = vld_pipe_q[WMEM_LAT-1];
    assign bus.mac_lane2    = lane_pipe_q[WMEM_LAT-1];
    assign bus.mac_ch       = ch_pipe_q[WMEM_LAT-1];
    assign bus.acc_clear    = acc_clear_q;
    assign bus.res_sel      = res_sel_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.class_id     = class_id_q;
    assign bus.class_score  = class_score_q;
`ifdef DENSE_PERF_EN
    assign bus.perf_stall   = perf_q;
`endif
endmodule
